// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

  // Address width; a 1-bit floor keeps tiny configurations legal.
  function automatic int calc_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Low bit of port p inside a packed multi-port bus.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

  localparam int DEF_DEPTH = 32;
  localparam int DEF_AW    = calc_aw(DEF_DEPTH);

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear engine: zeroes one storage entry per cycle after reset or on clr_req.
// A sweep lasts exactly DEPTH cycles; busy is decoded from the state register.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = calc_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  state_e        r_state;
  logic [AW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr_req) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
          end
        end
        CLEAR: begin
          r_ptr <= r_ptr + AW'(1);
          if (r_ptr == AW'(DEPTH - 1)) r_state <= IDLE;
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign busy     = (r_state == CLEAR);
  // No sweep write on a reset edge: the pointer is being reloaded.
  assign clr_we   = busy && rst;
  assign clr_addr = r_ptr;

endmodule

// File: rtl/regfile_mp.sv
// NRD-read / NWR-write register file with optional zero register, write bypass
// and a sequential clear sweep; highest-index write port wins on collisions.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = calc_aw(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_dout,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_din,
  input  logic [NWR-1:0]       we,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 wr_conflict
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_wr_conflict;
  logic             w_clr_we;
  logic [AW-1:0]    w_clr_addr;
  logic [NWR-1:0]   w_we_eff;
  logic             w_conflict;

  regfile_clear_fsm #(.DEPTH(DEPTH), .AW(AW)) u_clear (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  // Qualified enables: dropped while sweeping, and address 0 when hard-wired.
  for (genvar p = 0; p < NWR; p++) begin : g_we
    assign w_we_eff[p] = we[p] && rst && !busy &&
                         !(ZERO_REG && (wr_addr[slice_lo(p, AW) +: AW] == '0));
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int p = 0; p < NWR; p++)
      for (int q = p + 1; q < NWR; q++)
        if (w_we_eff[p] && w_we_eff[q] &&
            (wr_addr[slice_lo(p, AW) +: AW] == wr_addr[slice_lo(q, AW) +: AW]))
          w_conflict = 1'b1;
  end

  // Later loop iterations override earlier ones, giving high-index priority.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++)
        if (w_we_eff[p])
          r_mem[wr_addr[slice_lo(p, AW) +: AW]] <= wr_din[slice_lo(p, WIDTH) +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_wr_conflict <= 1'b0;
    else      r_wr_conflict <= w_conflict;
  end

  assign wr_conflict = r_wr_conflict;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]    w_ra;
    logic [WIDTH-1:0] w_rd;

    assign w_ra = rd_addr[slice_lo(i, AW) +: AW];

    always_comb begin
      w_rd = r_mem[w_ra];
      if (BYPASS)
        for (int p = 0; p < NWR; p++)
          if (w_we_eff[p] && (wr_addr[slice_lo(p, AW) +: AW] == w_ra))
            w_rd = wr_din[slice_lo(p, WIDTH) +: WIDTH];
      if (busy || (ZERO_REG && (w_ra == '0))) w_rd = '0;
    end

    assign rd_dout[slice_lo(i, WIDTH) +: WIDTH] = w_rd;
  end

endmodule
